// File: rtl/au_dac_formatter.sv
// Multi-channel FIR-to-DAC output stage: sample-rate strobe, per-sample gain,
// round/saturate to offset binary, per-channel DAC code hold and clip counter.
module au_dac_formatter #(
    parameter int CLK_DIV = 1250,
    parameter int IN_W    = 24,
    parameter int OUT_W   = 10,
    parameter int CH      = 2,
    parameter bit INVERT  = 1'b1,
    localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [IN_W-1:0]     din,
    input  logic                din_vld,
    input  logic [CHW-1:0]      din_ch,
    input  logic [2:0]          gain_sel,
    output logic                sample_tick,
    output logic                dac_clk,
    output logic [CH*OUT_W-1:0] dac_dat,
    output logic                dac_upd,
    output logic [15:0]         ovf_cnt
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam int PW = IN_W + 10;
    localparam logic signed [PW-1:0] RND     = PW'(64);
    localparam logic signed [PW-1:0] SAT_MAX = {{11{1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{11{1'b1}}, {(IN_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] ZERO_CODE = INVERT ? {1'b0, {(OUT_W-1){1'b1}}}
                                                    : {1'b1, {(OUT_W-1){1'b0}}};

    // ---------------- sample-rate strobe and frame-aligned gain ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [2:0]       gain_q, gain_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == CNT_LAST);
        gain_d = tick_q ? gain_sel : gain_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            gain_q <= 3'd3;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            gain_q <= gain_d;
        end
    end

    // ---------------- S1: channel qualify and gain multiply ----------------
    // din_vld is a valid-only strobe with no ready: every qualified beat is
    // consumed, one sample per cycle, and the pipeline never stalls.
    logic                  ch_ok;
    logic [3:0]            gain_p1;
    logic [9:0]            gmul;
    logic signed [PW-1:0]  din_x, gmul_x, prod;
    logic                  v1_q;
    logic [CHW-1:0]        ch1_q;
    logic signed [PW-1:0]  p_q;

    generate
        if ((1 << CHW) == CH) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = ({1'b0, din_ch} < (CHW+1)'(CH));
        end
    endgenerate

    always_comb begin
        gain_p1 = {1'b0, gain_q} + 4'd1;
        gmul    = {1'b0, gain_p1, 5'b00000};   // (gain_q+1)*32, Q2.7
        din_x   = {{10{din[IN_W-1]}}, din};
        gmul_x  = {{(PW-10){1'b0}}, gmul};
        prod    = din_x * gmul_x;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v1_q  <= 1'b0;
            ch1_q <= '0;
            p_q   <= '0;
        end else begin
            v1_q <= din_vld & ch_ok;
            if (din_vld && ch_ok) begin
                ch1_q <= din_ch;
                p_q   <= prod;
            end
        end
    end

    // ---------------- S2: round, saturate, format, lane write ----------------
    logic signed [PW-1:0]  sum, r_full;
    logic                  clip_hi, clip_lo;
    logic [OUT_W-1:0]      code;
    logic [CH*OUT_W-1:0]   dac_q, dac_d;
    logic                  upd_q;
    logic [15:0]           ovf_q, ovf_d;

    always_comb begin
        sum     = p_q + RND;
        r_full  = sum >>> 7;
        clip_hi = (r_full > SAT_MAX);
        clip_lo = (r_full < SAT_MIN);
        code    = r_full[IN_W-1 -: OUT_W];
        if (clip_hi) begin
            code = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (clip_lo) begin
            code = {1'b1, {(OUT_W-1){1'b0}}};
        end
        code[OUT_W-1] = ~code[OUT_W-1];
        if (INVERT) begin
            code = ~code;
        end

        dac_d = dac_q;
        if (v1_q) begin
            for (int n = 0; n < CH; n++) begin
                if (ch1_q == CHW'(n)) begin
                    dac_d[n*OUT_W +: OUT_W] = code;
                end
            end
        end

        ovf_d = ovf_q;
        if (v1_q && (clip_hi || clip_lo) && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dac_q <= {CH{ZERO_CODE}};
            upd_q <= 1'b0;
            ovf_q <= '0;
        end else begin
            dac_q <= dac_d;
            upd_q <= v1_q;
            ovf_q <= ovf_d;
        end
    end

    assign sample_tick = tick_q;
    assign dac_clk     = ~sys_clk;
    assign dac_dat     = dac_q;
    assign dac_upd     = upd_q;
    assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_au_dac_formatter.sv
// Directed bench for au_dac_formatter: one normal-polarity and one inverted
// instance share all inputs; expected codes are hand-computed constants.
module tb_au_dac_formatter;

    localparam int DIV = 1250;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [23:0] din;
    logic        din_vld;
    logic        din_ch;
    logic [2:0]  gain_sel;

    logic        tick0, dclk0, upd0, tick1, dclk1, upd1;
    logic [19:0] dat0, dat1;
    logic [15:0] ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    au_dac_formatter #(.CLK_DIV(DIV), .IN_W(24), .OUT_W(10), .CH(2), .INVERT(1'b0)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .din_vld(din_vld),
        .din_ch(din_ch), .gain_sel(gain_sel), .sample_tick(tick0), .dac_clk(dclk0),
        .dac_dat(dat0), .dac_upd(upd0), .ovf_cnt(ovf0)
    );

    au_dac_formatter #(.CLK_DIV(DIV), .IN_W(24), .OUT_W(10), .CH(2), .INVERT(1'b1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .din_vld(din_vld),
        .din_ch(din_ch), .gain_sel(gain_sel), .sample_tick(tick1), .dac_clk(dclk1),
        .dac_dat(dat1), .dac_upd(upd1), .ovf_cnt(ovf1)
    );

    // ---------------- clock / watchdog ----------------
    always #10 sys_clk = ~sys_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_sample(input logic ch, input logic [23:0] d);
        @(posedge sys_clk); #1;
        din_vld = 1'b1;
        din_ch  = ch;
        din     = d;
        @(posedge sys_clk); #1;
        din_vld = 1'b0;
    endtask

    // Returns at the negedge where sample_tick is high; gain loads at the next posedge.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 2*DIV && !seen; i++) begin
            @(negedge sys_clk);
            if (tick0 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_tick got no_tick exp tick within %0d cycles", 2*DIV);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_rst = 1'b1; din_vld = 1'b0; din = '0; din_ch = 1'b0; gain_sel = 3'd3;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++; if (tick0 !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", tick0); end
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL rst_upd got %b exp 0", upd0); end
        checks++; if (ovf0 !== 16'd0) begin errors++; $display("FAIL rst_ovf got %0d exp 0", ovf0); end
        checks++; if (dat0 !== {10'd512, 10'd512}) begin errors++; $display("FAIL rst_dat0 got %h exp %h", dat0, {10'd512, 10'd512}); end
        checks++; if (dat1 !== {10'd511, 10'd511}) begin errors++; $display("FAIL rst_dat1 got %h exp %h", dat1, {10'd511, 10'd511}); end
        checks++; if (dclk0 !== 1'b1) begin errors++; $display("FAIL dac_clk_low got %b exp 1", dclk0); end
        @(posedge sys_clk); #1;
        checks++; if (dclk0 !== 1'b0) begin errors++; $display("FAIL dac_clk_high got %b exp 0", dclk0); end
        sys_rst = 1'b0;
    endtask

    task automatic test_tick();
        logic exp;
        for (int k = 0; k < 3000; k++) begin
            @(negedge sys_clk);
            exp = (k == 1249) || (k == 2499);
            checks++;
            if (tick0 !== exp) begin
                errors++;
                $display("FAIL tick_cycle_%0d got %b exp %b", k, tick0, exp);
            end
        end
        checks++; if (dat0 !== {10'd512, 10'd512}) begin errors++; $display("FAIL tick_dat0 got %h exp %h", dat0, {10'd512, 10'd512}); end
    endtask

    task automatic test_unity();
        drive_sample(1'b0, 24'h400000);
        @(negedge sys_clk);
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL unity_early_upd got %b exp 0", upd0); end
        @(negedge sys_clk);
        checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL unity_upd got %b exp 1", upd0); end
        checks++; if (upd1 !== 1'b1) begin errors++; $display("FAIL unity_upd_inv got %b exp 1", upd1); end
        checks++; if (dat0[9:0] !== 10'd768) begin errors++; $display("FAIL unity_lane0 got %0d exp 768", dat0[9:0]); end
        checks++; if (dat0[19:10] !== 10'd512) begin errors++; $display("FAIL unity_lane1 got %0d exp 512", dat0[19:10]); end
        checks++; if (dat1[9:0] !== 10'd255) begin errors++; $display("FAIL unity_inv_lane0 got %0d exp 255", dat1[9:0]); end
        checks++; if (dat1[19:10] !== 10'd511) begin errors++; $display("FAIL unity_inv_lane1 got %0d exp 511", dat1[19:10]); end
        @(negedge sys_clk);
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL unity_upd_width got %b exp 0", upd0); end
    endtask

    task automatic test_saturate();
        gain_sel = 3'd7;
        wait_tick();
        drive_sample(1'b1, 24'h600000);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[19:10] !== 10'd1023) begin errors++; $display("FAIL sat_pos_lane1 got %0d exp 1023", dat0[19:10]); end
        checks++; if (dat0[9:0] !== 10'd768) begin errors++; $display("FAIL sat_pos_lane0_hold got %0d exp 768", dat0[9:0]); end
        checks++; if (ovf0 !== 16'd1) begin errors++; $display("FAIL sat_pos_ovf got %0d exp 1", ovf0); end
        checks++; if (dat1[19:10] !== 10'd0) begin errors++; $display("FAIL sat_pos_inv got %0d exp 0", dat1[19:10]); end
        drive_sample(1'b1, 24'hA00000);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[19:10] !== 10'd0) begin errors++; $display("FAIL sat_neg_lane1 got %0d exp 0", dat0[19:10]); end
        checks++; if (ovf0 !== 16'd2) begin errors++; $display("FAIL sat_neg_ovf got %0d exp 2", ovf0); end
        gain_sel = 3'd3;
        wait_tick();
        drive_sample(1'b1, 24'h600000);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[19:10] !== 10'd896) begin errors++; $display("FAIL unity_600000 got %0d exp 896", dat0[19:10]); end
        drive_sample(1'b1, 24'h800000);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[19:10] !== 10'd0) begin errors++; $display("FAIL min_no_clip got %0d exp 0", dat0[19:10]); end
        checks++; if (dat1[19:10] !== 10'd1023) begin errors++; $display("FAIL min_no_clip_inv got %0d exp 1023", dat1[19:10]); end
        checks++; if (ovf0 !== 16'd2) begin errors++; $display("FAIL min_no_clip_ovf got %0d exp 2", ovf0); end
    endtask

    task automatic test_rounding();
        gain_sel = 3'd0;
        wait_tick();
        drive_sample(1'b0, 24'h000002);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[9:0] !== 10'd512) begin errors++; $display("FAIL rnd_pos2 got %0d exp 512", dat0[9:0]); end
        drive_sample(1'b1, 24'hFFFFFE);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0 !== {10'd512, 10'd512}) begin errors++; $display("FAIL rnd_neg2 got %h exp %h", dat0, {10'd512, 10'd512}); end
        drive_sample(1'b0, 24'h00FFFE);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[9:0] !== 10'd513) begin errors++; $display("FAIL rnd_half_up got %0d exp 513", dat0[9:0]); end
        checks++; if (dat1[9:0] !== 10'd510) begin errors++; $display("FAIL rnd_half_up_inv got %0d exp 510", dat1[9:0]); end
        drive_sample(1'b1, 24'h00FFFD);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[19:10] !== 10'd512) begin errors++; $display("FAIL rnd_below_half got %0d exp 512", dat0[19:10]); end
        checks++; if (ovf0 !== 16'd2) begin errors++; $display("FAIL rnd_ovf got %0d exp 2", ovf0); end
    endtask

    task automatic test_gain_hold();
        gain_sel = 3'd3;
        wait_tick();
        @(posedge sys_clk); #1;
        gain_sel = 3'd7;
        drive_sample(1'b0, 24'h100000);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[9:0] !== 10'd576) begin errors++; $display("FAIL gain_midframe got %0d exp 576", dat0[9:0]); end
        wait_tick();
        din_vld = 1'b1; din_ch = 1'b1; din = 24'h100000;
        @(posedge sys_clk); #1;
        din_vld = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[19:10] !== 10'd576) begin errors++; $display("FAIL gain_tick_cycle got %0d exp 576", dat0[19:10]); end
        drive_sample(1'b0, 24'h100000);
        repeat (2) @(negedge sys_clk);
        checks++; if (dat0[9:0] !== 10'd640) begin errors++; $display("FAIL gain_after_tick got %0d exp 640", dat0[9:0]); end
        checks++; if (dat1[9:0] !== 10'd383) begin errors++; $display("FAIL gain_after_tick_inv got %0d exp 383", dat1[9:0]); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        gain_sel = 3'd3;
        wait_tick();
        @(posedge sys_clk); #1;
        din_vld = 1'b1; din_ch = 1'b0; din = 24'h400000;
        @(negedge sys_clk); if (upd0 === 1'b1) pulses++;
        @(posedge sys_clk); #1;
        din_ch = 1'b1; din = 24'h400000;
        @(negedge sys_clk); if (upd0 === 1'b1) pulses++;
        @(posedge sys_clk); #1;
        din_ch = 1'b0; din = 24'hC00000;
        @(negedge sys_clk); if (upd0 === 1'b1) pulses++;
        @(posedge sys_clk); #1;
        din_vld = 1'b0;
        @(negedge sys_clk); if (upd0 === 1'b1) pulses++;
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
        checks++; if (dat0 !== {10'd768, 10'd768}) begin errors++; $display("FAIL b2b_lanes got %h exp %h", dat0, {10'd768, 10'd768}); end
        #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL b2b_upd_in_rst got %b exp 0", upd0); end
        sys_rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge sys_clk); if (upd0 === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL b2b_upd_after_rst got %0d exp 0", pulses); end
        checks++; if (dat0 !== {10'd512, 10'd512}) begin errors++; $display("FAIL b2b_lanes_rst got %h exp %h", dat0, {10'd512, 10'd512}); end
        checks++; if (dat1 !== {10'd511, 10'd511}) begin errors++; $display("FAIL b2b_lanes_rst_inv got %h exp %h", dat1, {10'd511, 10'd511}); end
        checks++; if (ovf0 !== 16'd0) begin errors++; $display("FAIL b2b_ovf_rst got %0d exp 0", ovf0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tick();
        test_unity();
        test_saturate();
        test_rounding();
        test_gain_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
